ldl_tick_gen: RTL and testbench

Programmable prescaler/burst tick generator that produces the single-cycle enable strobe driving a downstream count stage's `en` input.
- Converts `clk` into one tick every (div+1) cycles.
- Runs either continuously or for a fixed burst of N ticks.
- Start/stop control; busy and done status.
- Sits directly upstream of the LDL counter blocks in timer and sequencer paths.

---
 rtl/ldl_tick_gen.sv | 129 ++++++++++++
 tb/tb_ldl_tick_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ldl_tick_gen.sv
// ldl_tick_gen: programmable prescaler / burst tick generator.
// Emits a registered single-cycle `tick` every (div+1) clocks, either
// continuously (burst=0) or for a finite burst of `burst` ticks ending
// with a coincident `done` pulse. div/burst are latched when a run starts.
// Optional build macro: LDL_TICK_GEN_RESTART_EN -- when defined, start
// asserted during a run restarts it with freshly latched div/burst.
module ldl_tick_gen #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [DIV_W-1:0] prescaler;
  logic [DIV_W-1:0] prescaler_nx;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_q_nx;
  logic [CNT_W-1:0] burst_q;
  logic [CNT_W-1:0] burst_q_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             tick_nx;
  logic             done_nx;
  logic             busy_nx;
  logic             tick_due;
  logic             last_tick;
  logic             restart;

  // A tick is due when the prescaler has reached the latched divisor.
  assign tick_due  = (prescaler == div_q);

  // The due tick is the final one of a finite burst.
  assign last_tick = (burst_q != '0) && (tick_cnt == (burst_q - CNT_W'(1)));

`ifdef LDL_TICK_GEN_RESTART_EN
  assign restart = start;
`else
  assign restart = 1'b0;
`endif

  // Next-state and next-output decode; stop outranks restart, which outranks a due tick.
  always_comb begin
    state_nx     = state;
    prescaler_nx = prescaler;
    div_q_nx     = div_q;
    burst_q_nx   = burst_q;
    cnt_nx       = tick_cnt;
    tick_nx      = 1'b0;
    done_nx      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nx     = RUN;
          div_q_nx     = div;
          burst_q_nx   = burst;
          prescaler_nx = '0;
          cnt_nx       = '0;
        end
      end

      RUN: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (restart) begin
          div_q_nx     = div;
          burst_q_nx   = burst;
          prescaler_nx = '0;
          cnt_nx       = '0;
        end else if (tick_due) begin
          prescaler_nx = '0;
          tick_nx      = 1'b1;
          cnt_nx       = tick_cnt + CNT_W'(1);
          if (last_tick) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end else begin
          prescaler_nx = prescaler + DIV_W'(1);
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx == RUN);
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prescaler <= '0;
      div_q     <= '0;
      burst_q   <= '0;
      tick_cnt  <= '0;
      tick      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      prescaler <= prescaler_nx;
      div_q     <= div_q_nx;
      burst_q   <= burst_q_nx;
      tick_cnt  <= cnt_nx;
      tick      <= tick_nx;
      done      <= done_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_ldl_tick_gen.sv
// Self-checking bench for ldl_tick_gen: each vector drives inputs for one
// edge and queues its expected outputs; the entry is popped and compared
// just after that edge.
module tb_ldl_tick_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] div;
  logic [7:0] burst;
  logic       tick;
  logic       busy;
  logic       done;
  logic [7:0] tick_cnt;

  int total = 0;
  int bad   = 0;
  string cur_name = "";
  int    vec_idx  = 0;

  typedef struct {
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] div;
    logic [7:0] burst;
    logic       tick;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } vec_t;

  vec_t exp_q[$];

  ldl_tick_gen #(.DIV_W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .div      (div),
    .burst    (burst),
    .tick     (tick),
    .busy     (busy),
    .done     (done),
    .tick_cnt (tick_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(logic r, logic s, logic p, logic [7:0] d, logic [7:0] b,
                              logic t, logic bz, logic dn, logic [7:0] c);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.div = d; v.burst = b;
    v.tick = t; v.busy = bz; v.done = dn; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string what, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s[%0d].%s: got %0h expected %0h", cur_name, vec_idx, what, act, expv);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; start = v.start; stop = v.stop; div = v.div; burst = v.burst;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s[%0d].queue: got empty expected entry", cur_name, vec_idx);
    end else begin
      e = exp_q.pop_front();
      chk("tick", {7'd0, tick}, {7'd0, e.tick});
      chk("busy", {7'd0, busy}, {7'd0, e.busy});
      chk("done", {7'd0, done}, {7'd0, e.done});
      chk("tick_cnt", tick_cnt, e.cnt);
    end
    vec_idx++;
  endtask

  initial begin
    vec_t t1 [11];
    int   c;

    // Test 1 table: div=2 burst=3, ticks after edges 3, 6, 9.
    t1[0]  = mk(0, 1, 0, 2, 3, 0, 1, 0, 0);
    t1[1]  = mk(0, 0, 0, 2, 3, 0, 1, 0, 0);
    t1[2]  = mk(0, 0, 0, 2, 3, 0, 1, 0, 0);
    t1[3]  = mk(0, 0, 0, 2, 3, 1, 1, 0, 1);
    t1[4]  = mk(0, 0, 0, 2, 3, 0, 1, 0, 1);
    t1[5]  = mk(0, 0, 0, 2, 3, 0, 1, 0, 1);
    t1[6]  = mk(0, 0, 0, 2, 3, 1, 1, 0, 2);
    t1[7]  = mk(0, 0, 0, 2, 3, 0, 1, 0, 2);
    t1[8]  = mk(0, 0, 0, 2, 3, 0, 1, 0, 2);
    t1[9]  = mk(0, 0, 0, 2, 3, 1, 0, 1, 3);
    t1[10] = mk(0, 0, 0, 2, 3, 0, 0, 0, 3);

    rst = 1'b1; start = 1'b0; stop = 1'b0; div = '0; burst = '0;

    cur_name = "reset"; vec_idx = 0;
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 1, 0, 5, 5, 0, 0, 0, 0));

    cur_name = "burst3"; vec_idx = 0;
    for (int i = 0; i < 11; i++) apply(t1[i]);

    // Test 2: div=0 continuous, 300 ticks, counter wraps.
    cur_name = "cont"; vec_idx = 0;
    apply(mk(0, 1, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 300; k++) apply(mk(0, 0, 0, 0, 0, 1, 1, 0, 8'(k)));
    apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 8'(300)));

    // Test 3: stop on the edge where the 3rd tick is due.
    cur_name = "stop"; vec_idx = 0;
    apply(mk(0, 1, 0, 4, 10, 0, 1, 0, 0));
    for (int k = 1; k <= 14; k++) apply(mk(0, 0, 0, 4, 10, (k % 5) == 0, 1, 0, 8'(k / 5)));
    apply(mk(0, 0, 1, 4, 10, 0, 0, 0, 2));
    for (int k = 0; k < 3; k++) apply(mk(0, 0, 0, 4, 10, 0, 0, 0, 2));

    // Test 4: start+stop together in IDLE, then reset mid-run.
    cur_name = "startstop"; vec_idx = 0;
    for (int k = 0; k < 3; k++) apply(mk(0, 1, 1, 1, 0, 0, 0, 0, 2));
    apply(mk(0, 1, 0, 1, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 4; k++) apply(mk(0, 0, 0, 1, 0, (k % 2) == 0, 1, 0, 8'(k / 2)));
    apply(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));

    // Test 5: div/burst inputs change mid-run; latched 3/5 must hold.
    cur_name = "latch"; vec_idx = 0;
    apply(mk(0, 1, 0, 3, 5, 0, 1, 0, 0));
    for (int k = 1; k <= 24; k++) begin
      c = (k / 4 > 5) ? 5 : k / 4;
      apply(mk(0, 0, 0, 0, 1, ((k % 4) == 0) && (k <= 20), k < 20, k == 20, 8'(c)));
    end

    // Test 6: start again after 2 ticks of a div=1 burst=4 run.
    cur_name = "restart"; vec_idx = 0;
    apply(mk(0, 1, 0, 1, 4, 0, 1, 0, 0));
    for (int k = 1; k <= 4; k++) apply(mk(0, 0, 0, 1, 4, (k % 2) == 0, 1, 0, 8'(k / 2)));
`ifdef LDL_TICK_GEN_RESTART_EN
    apply(mk(0, 1, 0, 1, 4, 0, 1, 0, 0));
    for (int j = 1; j <= 8; j++) apply(mk(0, 0, 0, 1, 4, (j % 2) == 0, j < 8, j == 8, 8'(j / 2)));
    apply(mk(0, 0, 0, 1, 4, 0, 0, 0, 4));
`else
    apply(mk(0, 1, 0, 1, 4, 0, 1, 0, 2));
    apply(mk(0, 0, 0, 1, 4, 1, 1, 0, 3));
    apply(mk(0, 0, 0, 1, 4, 0, 1, 0, 3));
    apply(mk(0, 0, 0, 1, 4, 1, 0, 1, 4));
    apply(mk(0, 0, 0, 1, 4, 0, 0, 0, 4));
`endif

    // Test 7: new start on the edge right after done; one idle-tick gap.
    cur_name = "b2b"; vec_idx = 0;
    apply(mk(0, 1, 0, 0, 2, 0, 1, 0, 0));
    apply(mk(0, 0, 0, 0, 2, 1, 1, 0, 1));
    apply(mk(0, 0, 0, 0, 2, 1, 0, 1, 2));
    apply(mk(0, 1, 0, 0, 2, 0, 1, 0, 0));
    apply(mk(0, 0, 0, 0, 2, 1, 1, 0, 1));
    apply(mk(0, 0, 0, 0, 2, 1, 0, 1, 2));
    apply(mk(0, 0, 0, 0, 2, 0, 0, 0, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
